// File: rtl/rv_interrupt_controller.sv
// Fixed-priority interrupt controller with per-source edge/level capture,
// a valid/ready presentation handshake and one tracked in-service interrupt.
module rv_interrupt_controller #(
   parameter int unsigned          N_SOURCES = 8,
   parameter logic [N_SOURCES-1:0] EDGE_MASK = '0,
   localparam int unsigned         CAUSE_W   = (N_SOURCES > 1) ? $clog2(N_SOURCES) : 1
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic [N_SOURCES-1:0] i_irq_src,
   input  logic [N_SOURCES-1:0] i_irq_enable,
   input  logic                 i_eoi,
   output logic                 o_int_valid,
   input  logic                 i_int_ready,
   output logic [CAUSE_W-1:0]   o_int_cause,
   output logic                 o_in_service,
   output logic [N_SOURCES-1:0] o_pending
);

   typedef enum logic [1:0] {StIdle, StPresent, StService} state_e;

   state_e               r_state;
   state_e               w_state_d;
   logic [N_SOURCES-1:0] r_src;
   logic [N_SOURCES-1:0] r_pending;
   logic [N_SOURCES-1:0] w_pending_d;
   logic [N_SOURCES-1:0] w_req;
   logic [CAUSE_W-1:0]   r_cause;
   logic [CAUSE_W-1:0]   w_cause_d;
   logic [CAUSE_W-1:0]   w_winner;
   logic                 w_accept;

   assign w_req    = r_pending & i_irq_enable;
   assign w_accept = (r_state == StPresent) && i_int_ready;

   // Lowest set index of the enabled request vector wins.
   always_comb begin
      w_winner = '0;
      for (int i = int'(N_SOURCES) - 1; i >= 0; i--) begin
         if (w_req[i]) begin
            w_winner = CAUSE_W'(i);
         end
      end
   end

   // Pending capture: edge sources latch until accepted (a fresh edge in the
   // accept cycle keeps the bit set); level sources simply follow the line.
   always_comb begin
      w_pending_d = '0;
      for (int i = 0; i < int'(N_SOURCES); i++) begin
         if (EDGE_MASK[i]) begin
            w_pending_d[i] = (i_irq_src[i] & ~r_src[i]) |
                             (r_pending[i] & ~(w_accept && (r_cause == CAUSE_W'(i))));
         end else begin
            w_pending_d[i] = i_irq_src[i];
         end
      end
   end

   // Next-state logic; the presented cause is frozen from PRESENT until IDLE.
   always_comb begin
      w_state_d = r_state;
      w_cause_d = r_cause;
      unique case (r_state)
         StIdle: begin
            if (|w_req) begin
               w_state_d = StPresent;
               w_cause_d = w_winner;
            end
         end
         StPresent: begin
            if (i_int_ready) begin
               w_state_d = StService;
            end
         end
         StService: begin
            if (i_eoi) begin
               w_state_d = StIdle;
            end
         end
         default: begin
            w_state_d = StIdle;
         end
      endcase
   end

   // State, cause, source history and pending registers.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state   <= StIdle;
         r_cause   <= '0;
         r_src     <= '0;
         r_pending <= '0;
      end else begin
         r_state   <= w_state_d;
         r_cause   <= w_cause_d;
         r_src     <= i_irq_src;
         r_pending <= w_pending_d;
      end
   end

   // Outputs decode directly from registered state so reset drops them at once.
   always_comb begin
      o_int_valid  = (r_state == StPresent);
      o_in_service = (r_state == StService);
      o_int_cause  = r_cause;
      o_pending    = r_pending;
   end

endmodule

// File: tb/tb_rv_interrupt_controller.sv
// Scoreboard bench: stimulus pushes expected causes, a monitor pops and
// compares them on each new presentation and checks cause stability.
module tb_rv_interrupt_controller;

   localparam int unsigned N = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [N-1:0] irq_src = '0;
   logic [N-1:0] irq_enable = '0;
   logic         eoi = 1'b0;
   logic         int_ready = 1'b0;
   logic         int_valid;
   logic [2:0]   int_cause;
   logic         in_service;
   logic [N-1:0] pending;

   int unsigned  n_checks = 0;
   int unsigned  n_fail = 0;
   int unsigned  exp_q[$];
   logic         prev_valid = 1'b0;
   logic [2:0]   held_cause = '0;

   rv_interrupt_controller #(
      .N_SOURCES (N),
      .EDGE_MASK (8'h07)
   ) dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_irq_src    (irq_src),
      .i_irq_enable (irq_enable),
      .i_eoi        (eoi),
      .o_int_valid  (int_valid),
      .i_int_ready  (int_ready),
      .o_int_cause  (int_cause),
      .o_in_service (in_service),
      .o_pending    (pending)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_valid(input string name, input int budget);
      for (int i = 0; i < budget && !int_valid; i++) tick(1);
      check(name, {31'b0, int_valid}, 32'd1);
   endtask

   task automatic accept();
      int_ready = 1'b1;
      tick(1);
      int_ready = 1'b0;
   endtask

   task automatic pulse_eoi();
      eoi = 1'b1;
      tick(1);
      eoi = 1'b0;
   endtask

   // Monitor: every new presentation must match the head of the scoreboard.
   always @(negedge clk) begin
      if (int_valid) begin
         if (!prev_valid) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_present: cause %0d presented, none expected at %0t",
                        int_cause, $time);
            end else begin
               check("present_cause", {29'b0, int_cause}, exp_q.pop_front());
            end
            held_cause = int_cause;
         end else begin
            check("cause_stable", {29'b0, int_cause}, {29'b0, held_cause});
         end
      end
      prev_valid = int_valid;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // 1. Reset holds everything low while sources toggle.
      irq_enable = 8'hFF;
      for (int i = 0; i < 4; i++) begin
         irq_src = (i % 2 == 0) ? 8'hFF : 8'h00;
         tick(1);
      end
      check("rst_valid", {31'b0, int_valid}, 32'd0);
      check("rst_cause", {29'b0, int_cause}, 32'd0);
      check("rst_in_service", {31'b0, in_service}, 32'd0);
      check("rst_pending", {24'b0, pending}, 32'd0);
      irq_src = '0;
      tick(1);
      rst_n = 1'b1;
      tick(4);
      check("post_rst_valid", {31'b0, int_valid}, 32'd0);

      // 2. Single edge on source 0: pending after 1 edge, valid after 2.
      irq_enable = 8'h01;
      exp_q.push_back(0);
      irq_src[0] = 1'b1;
      tick(1);
      irq_src[0] = 1'b0;
      check("edge_pending0", {31'b0, pending[0]}, 32'd1);
      check("edge_not_yet_valid", {31'b0, int_valid}, 32'd0);
      tick(1);
      check("edge_valid_t2", {31'b0, int_valid}, 32'd1);
      tick(1);
      accept();
      check("edge_in_service", {31'b0, in_service}, 32'd1);
      check("edge_valid_dropped", {31'b0, int_valid}, 32'd0);
      check("edge_pending_cleared", {31'b0, pending[0]}, 32'd0);
      pulse_eoi();
      check("edge_eoi_idle", {31'b0, in_service}, 32'd0);
      tick(5);
      check("edge_no_repeat", {31'b0, int_valid}, 32'd0);

      // 3. Level sources 3 and 5: 3 wins, then 5 one cycle after eoi.
      irq_enable = 8'hFF;
      exp_q.push_back(3);
      irq_src[3] = 1'b1;
      irq_src[5] = 1'b1;
      wait_valid("prio_wait3", 10);
      accept();
      irq_src[3] = 1'b0;
      tick(1);
      exp_q.push_back(5);
      pulse_eoi();
      tick(1);
      check("prio_next_valid", {31'b0, int_valid}, 32'd1);
      check("prio_next_cause", {29'b0, int_cause}, 32'd5);

      // 4. No retraction: enable[5] drops and src1 edges while ready is low.
      irq_enable[5] = 1'b0;
      irq_src[1] = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick(1);
         check("hold_valid", {31'b0, int_valid}, 32'd1);
         check("hold_cause", {29'b0, int_cause}, 32'd5);
      end
      irq_src[1] = 1'b0;
      accept();
      irq_src[5] = 1'b0;
      exp_q.push_back(1);
      pulse_eoi();
      wait_valid("hold_then_src1", 10);
      accept();
      pulse_eoi();
      irq_enable = 8'hFF;
      tick(3);

      // 5. New edge on source 2 in its accept cycle keeps it pending.
      exp_q.push_back(2);
      irq_src[2] = 1'b1;
      tick(1);
      irq_src[2] = 1'b0;
      wait_valid("clr_wait2", 10);
      irq_src[2] = 1'b1;
      accept();
      irq_src[2] = 1'b0;
      check("clr_in_service", {31'b0, in_service}, 32'd1);
      check("clr_pending_kept", {31'b0, pending[2]}, 32'd1);
      exp_q.push_back(2);
      pulse_eoi();
      wait_valid("clr_represent", 10);
      accept();
      check("clr_pending_now_clear", {31'b0, pending[2]}, 32'd0);
      pulse_eoi();
      tick(3);

      // 6. Asynchronous reset while in service.
      exp_q.push_back(4);
      irq_src[4] = 1'b1;
      wait_valid("arst_wait4", 10);
      accept();
      check("arst_in_service_before", {31'b0, in_service}, 32'd1);
      #2;
      rst_n = 1'b0;
      irq_src = '0;
      #1;
      check("arst_in_service", {31'b0, in_service}, 32'd0);
      check("arst_valid", {31'b0, int_valid}, 32'd0);
      check("arst_pending", {24'b0, pending}, 32'd0);
      tick(2);
      rst_n = 1'b1;
      tick(5);
      check("arst_idle_after", {31'b0, int_valid}, 32'd0);

      check("queue_drained", exp_q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
